// File: rtl/ts_responder.sv
// ts_responder: far-end agent on a 4-line tristate bus.
// Captures every peer-driven cycle into a small FIFO. Drives response nibbles
// back onto the bus once the peer has been quiet for TA cycles.
module ts_responder #(
  parameter int DEPTH = 4,
  parameter int TA    = 2,
  parameter int HOLD  = 1
) (
  input  logic       clk,
  input  logic       reset,
  inout  wire        ts_0,
  inout  wire        ts_1,
  inout  wire        ts_2,
  inout  wire        ts_3,
  input  logic [3:0] peer_drive,
  output logic       cap_valid,
  input  logic       cap_ready,
  output logic [3:0] cap_data,
  output logic [3:0] cap_mask,
  input  logic       resp_valid,
  output logic       resp_ready,
  input  logic [3:0] resp_data,
  input  logic [3:0] resp_mask,
  output logic [3:0] own_oe,
  output logic       overflow,
  output logic       contention
);

  localparam int AW = $clog2(DEPTH);
  localparam int QW = $clog2(TA + 1);
  localparam int HW = (HOLD > 1) ? $clog2(HOLD) : 1;
  localparam logic [QW-1:0] TA_Q    = QW'(TA);
  localparam logic [HW-1:0] HOLD_M1 = HW'(HOLD - 1);

  typedef enum logic [1:0] {IDLE, DRIVE, GUARD} state_t;

  state_t          state_q, state_d;
  logic [HW-1:0]   hcnt_q, hcnt_d;
  logic [3:0]      dat_q, dat_d, msk_q, msk_d;
  logic [QW-1:0]   quiet_q, quiet_d;
  logic [7:0]      mem_q [DEPTH];
  logic [AW:0]     wr_q, rd_q;
  logic            ovf_q, cont_q;

  logic [3:0] bus, drive_req;
  logic [7:0] head;
  logic       push, pop, full, empty, wr_en;

  // Bus sampling and per-line drive; peer-owned lines are released at once.
  assign bus       = {ts_3, ts_2, ts_1, ts_0};
  assign drive_req = (state_q == DRIVE) ? msk_q : 4'b0000;
  assign own_oe    = drive_req & ~peer_drive;
  assign ts_0      = own_oe[0] ? dat_q[0] : 1'bz;
  assign ts_1      = own_oe[1] ? dat_q[1] : 1'bz;
  assign ts_2      = own_oe[2] ? dat_q[2] : 1'bz;
  assign ts_3      = own_oe[3] ? dat_q[3] : 1'bz;

  // FIFO status; the extra pointer bit separates full from empty.
  assign empty     = (wr_q == rd_q);
  assign full      = (wr_q[AW] != rd_q[AW]) && (wr_q[AW-1:0] == rd_q[AW-1:0]);
  assign push      = |peer_drive;
  assign pop       = !empty && cap_ready;
  assign wr_en     = push && (!full || pop);
  assign head      = mem_q[rd_q[AW-1:0]];
  assign cap_valid = !empty;
  assign cap_mask  = empty ? 4'b0000 : head[7:4];
  assign cap_data  = empty ? 4'b0000 : head[3:0];
  assign overflow  = ovf_q;
  assign contention = cont_q;

  // Quiet counter: cycles since the peer last drove, saturating at TA.
  always_comb begin
    quiet_d = quiet_q;
    if (push)                 quiet_d = '0;
    else if (quiet_q != TA_Q) quiet_d = quiet_q + 1'b1;
  end

  // Response FSM next state; resp_ready is held low while in reset.
  always_comb begin
    state_d    = state_q;
    hcnt_d     = hcnt_q;
    dat_d      = dat_q;
    msk_d      = msk_q;
    resp_ready = 1'b0;
    case (state_q)
      IDLE: if (!reset && resp_valid && quiet_q == TA_Q &&
                (peer_drive & resp_mask) == 4'b0000) begin
        resp_ready = 1'b1;
        dat_d      = resp_data;
        msk_d      = resp_mask;
        hcnt_d     = '0;
        state_d    = DRIVE;
      end
      DRIVE: if (hcnt_q == HOLD_M1) state_d = GUARD;
             else                   hcnt_d  = hcnt_q + 1'b1;
      GUARD:   state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // Control state, FIFO pointers and sticky flags.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      hcnt_q  <= '0;
      dat_q   <= 4'b0000;
      msk_q   <= 4'b0000;
      quiet_q <= TA_Q;
      wr_q    <= '0;
      rd_q    <= '0;
      ovf_q   <= 1'b0;
      cont_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      dat_q   <= dat_d;
      msk_q   <= msk_d;
      quiet_q <= quiet_d;
      if (wr_en) wr_q <= wr_q + 1'b1;
      if (pop)   rd_q <= rd_q + 1'b1;
      if (push && full && !pop)        ovf_q  <= 1'b1;
      if (|(drive_req & peer_drive))   cont_q <= 1'b1;
    end
  end

  // Capture storage: {mask, data restricted to peer-driven lines}.
  always_ff @(posedge clk) begin
    if (!reset && wr_en) mem_q[wr_q[AW-1:0]] <= {peer_drive, bus & peer_drive};
  end

endmodule
